// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared types for the fetch sequencer slice.
//   - pc_seq_state_e : sequencer FSM states (RESET, FETCH, HOLD, DRAIN).
//     The encodings come from plain localparam constants so that older
//     code which compares raw state bits can keep doing so.
//   - pc_seq_redir_e : which redirect source, if any, owns pc_next this cycle.
//   - redir_select() : resolves simultaneous redirect requests. An exception
//     always beats a branch.
package pc_seq_pkg;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    RESET = ST_RESET,
    FETCH = ST_FETCH,
    HOLD  = ST_HOLD,
    DRAIN = ST_DRAIN
  } pc_seq_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_EXC  = 2'd2
  } pc_seq_redir_e;

  // An exception outranks a branch that arrives in the same cycle.
  function automatic pc_seq_redir_e redir_select(input logic br, input logic exc);
    if (exc) begin
      return REDIR_EXC;
    end
    if (br) begin
      return REDIR_BR;
    end
    return REDIR_NONE;
  endfunction

endpackage

// File: rtl/pc_hold_buf.sv
// pc_hold_buf
// One-entry buffer for an instruction word and its address. It keeps a
// fetched instruction while decode is stalling, so that imem can be released.
// Ports:
//   clk, rst         clock; asynchronous active-high reset (clears the entry)
//   load             capture load_instr/load_pc on the next clock edge
//   clear            drop the entry (clear takes priority over load)
//   load_instr       instruction word to capture
//   load_pc          address of that instruction
//   instr, pc        stored entry
module pc_hold_buf
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc
);

  // The entry has no valid bit of its own. The sequencer's HOLD state
  // records whether the contents are live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch sequencer placed between the pc register, instruction memory and decode.
// It computes pc_next for the pc register and owns the imem req/ack handshake.
// It hands fetched words to decode over valid/ready, and uses a one-entry hold
// buffer when decode stalls. Branch and exception redirects are applied here,
// and any fetch still in flight to a stale address is discarded.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   pc / pc_next             pc register output / input
//   imem_req, imem_addr      fetch request; the address is stable until the ack
//   imem_ack, imem_rdata     single-cycle completion pulse with its data
//   instr_valid/instr_ready  decode handshake
//   instr, instr_pc          delivered word and its address
//   br_valid, br_target      branch/jump redirect
//   exc_valid                exception redirect to EXC_VECTOR
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter int unsigned          INSTR_WIDTH  = 32,
  parameter int unsigned          PC_INC       = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0]  EXC_VECTOR   = PC_WIDTH'('h80)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pc_next,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   br_valid,
  input  logic [PC_WIDTH-1:0]    br_target,
  input  logic                   exc_valid
);

  pc_seq_state_e          state;
  pc_seq_state_e          state_nxt;
  pc_seq_redir_e          redir_sel;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redir_target;
  logic [PC_WIDTH-1:0]    inc_pc;
  logic [PC_WIDTH-1:0]    addr_q;
  logic                   buf_load;
  logic                   buf_clear;
  logic [INSTR_WIDTH-1:0] buf_instr;
  logic [PC_WIDTH-1:0]    buf_pc;

  // Redirect resolution and the sequential increment. Redirects that arrive
  // while the FSM is still in RESET are ignored. The increment wraps naturally
  // at PC_WIDTH bits.
  always_comb begin
    redir_sel    = redir_select(br_valid, exc_valid);
    redirect     = (state != RESET) && (redir_sel != REDIR_NONE);
    redir_target = (redir_sel == REDIR_EXC) ? EXC_VECTOR : br_target;
    inc_pc       = pc + PC_WIDTH'(PC_INC);
  end

  // Next-pc mux, imem handshake and the decode interface.
  // In FETCH, an ack is forwarded to decode in the same cycle, so a 0-wait
  // memory sustains one instruction per cycle. A stall parks the word in the
  // hold buffer. A redirect with no ack pending leaves a request outstanding
  // to the old address. DRAIN keeps that request stable on addr_q until its
  // ack arrives, and then discards the returned data.
  always_comb begin
    state_nxt   = state;
    pc_next     = pc;
    imem_req    = 1'b0;
    imem_addr   = pc;
    instr_valid = 1'b0;
    instr       = buf_instr;
    instr_pc    = buf_pc;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;

    case (state)
      RESET: begin
        state_nxt = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr    = imem_rdata;
          instr_pc = pc;
          if (redirect) begin
            pc_next = redir_target;
          end else begin
            instr_valid = 1'b1;
            if (instr_ready) begin
              pc_next = inc_pc;
            end else begin
              buf_load  = 1'b1;
              state_nxt = HOLD;
            end
          end
        end else if (redirect) begin
          pc_next   = redir_target;
          state_nxt = DRAIN;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_next   = redir_target;
          buf_clear = 1'b1;
          state_nxt = FETCH;
        end else begin
          instr_valid = 1'b1;
          if (instr_ready) begin
            pc_next   = inc_pc;
            state_nxt = FETCH;
          end
        end
      end

      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (redirect) begin
          pc_next = redir_target;
        end
        if (imem_ack) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = RESET;
      end
    endcase

    // While reset is held, the pc register must be steered to the reset vector.
    if (rst) begin
      pc_next = RESET_VECTOR;
    end
  end

  // State register. addr_q tracks the address being requested in FETCH.
  // If a redirect sends the FSM to DRAIN, addr_q still holds the stale
  // address that imem is working on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RESET;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        addr_q <= pc;
      end
    end
  end

  pc_hold_buf #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Bench for pc_sequencer. It wraps the DUT with a pc register and an
// instruction memory whose word at each address is a fixed function of that
// address. A program-order reference model sits in a queue: it holds the
// address decode should receive next. The model moves to addr+4 on every
// accepted instruction, and a redirect replaces it with the redirect target.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  pc;
  logic [7:0]  pc_next;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        exc_valid;

  int          total = 0;
  int          bad = 0;
  int          acceptCount = 0;
  int          waitLeft = 0;
  logic [7:0]  expQ[$];

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .exc_valid   (exc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pc register in front of the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 8'h00;
    else     pc <= pc_next;
  end

  function automatic logic [31:0] memWord(input logic [7:0] a);
    return {a ^ 8'h5A, ~a, a + 8'd17, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // Runs one clock cycle. Inputs are driven just after the rising edge and the
  // task returns at the falling edge, where outputs are stable. With autoAck
  // set, the memory answers after a random wait of 0..2 cycles.
  task automatic applyStimulus(input bit autoAck, input logic ack, input logic ready,
                               input logic br, input logic [7:0] tgt, input logic exc);
    logic a;
    @(posedge clk);
    #1;
    a = ack;
    if (autoAck) begin
      a = 1'b0;
      if (imem_req) begin
        if (waitLeft == 0) begin
          a = 1'b1;
          waitLeft = $urandom_range(0, 2);
        end else begin
          waitLeft--;
        end
      end
    end
    imem_ack    = a;
    imem_rdata  = a ? memWord(imem_addr) : 32'hDEADBEEF;
    instr_ready = ready;
    br_valid    = br;
    br_target   = tgt;
    exc_valid   = exc;
    if (br || exc) begin
      expQ.delete();
      expQ.push_back(exc ? 8'h80 : tgt);
    end
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pc_next"},     32'(pc_next),     32'h0);
    checkOutput({tag, "_imem_req"},    32'(imem_req),    32'h0);
    checkOutput({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    checkOutput({tag, "_instr"},       instr,            32'h0);
    checkOutput({tag, "_instr_pc"},    32'(instr_pc),    32'h0);
  endtask

  task automatic doReset();
    #1;
    rst = 1'b1;
    imem_ack = 1'b0; instr_ready = 1'b0; br_valid = 1'b0; exc_valid = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkResetOutputs("reset");
    #1;
    rst = 1'b0;
    expQ.push_back(8'h00);
    waitLeft = 0;
  endtask

  // Monitor and scoreboard. On each handshake it pops the expected address and
  // compares it with the delivered instruction. It also checks request
  // stability and that a redirect kills instr_valid.
  initial begin : monitor
    logic       prevReq;
    logic       prevAck;
    logic [7:0] prevAddr;
    logic [7:0] exp;
    prevReq = 1'b0; prevAck = 1'b0; prevAddr = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevReq = 1'b0;
      end else begin
        if (br_valid || exc_valid)
          checkOutput("redirect_kills_valid", 32'(instr_valid), 32'h0);
        if (prevReq && !prevAck && imem_req)
          checkOutput("imem_addr_stable", 32'(imem_addr), 32'(prevAddr));
        if (instr_valid && instr_ready) begin
          if (expQ.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL sb_unexpected: got instr_pc 'h%0h, expected no delivery", instr_pc);
          end else begin
            exp = expQ.pop_front();
            checkOutput("sb_instr_pc", 32'(instr_pc), 32'(exp));
            checkOutput("sb_instr_word", instr, memWord(exp));
            expQ.push_back(exp + 8'd4);
            acceptCount++;
          end
        end
        prevReq = imem_req; prevAck = imem_ack; prevAddr = imem_addr;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    br_valid = 1'b0; br_target = 8'h00; exc_valid = 1'b0;
    doReset();

    // Zero-wait memory with decode always ready: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("seq_instr_valid", 32'(instr_valid), 32'h1);
      checkOutput("seq_instr_pc",    32'(instr_pc),    32'(i * 4));
      checkOutput("seq_pc_next",     32'(pc_next),     32'((i + 1) * 4));
    end

    // Stall on the second instruction; it is held in the buffer.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("stall_ack_valid",   32'(instr_valid), 32'h1);
    checkOutput("stall_ack_pc_next", 32'(pc_next),     32'h4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("hold_imem_req", 32'(imem_req),    32'h0);
      checkOutput("hold_valid",    32'(instr_valid), 32'h1);
      checkOutput("hold_instr",    instr,            memWord(8'h04));
      checkOutput("hold_instr_pc", 32'(instr_pc),    32'h4);
      checkOutput("hold_pc_next",  32'(pc_next),     32'h4);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("hold_release_pc_next", 32'(pc_next), 32'h8);

    // Branch while the fetch at 8 waits for its ack: drain, then fetch 'h40.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("fetch8_req",  32'(imem_req),  32'h1);
    checkOutput("fetch8_addr", 32'(imem_addr), 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
    checkOutput("br_pc_next", 32'(pc_next), 32'h40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("drain_req",   32'(imem_req),    32'h1);
    checkOutput("drain_addr",  32'(imem_addr),   32'h8);
    checkOutput("drain_valid", 32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("drain_ack_discard", 32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("after_drain_addr", 32'(imem_addr), 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("target_instr_pc", 32'(instr_pc), 32'h40);

    // Branch and exception in the same cycle: the exception wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1);
    checkOutput("exc_prio_pc_next", 32'(pc_next), 32'h80);

    // Wrap: branch to 'hFC, drain the stale fetch, then accept at 'hFC.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hFC, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("wrap_instr_pc", 32'(instr_pc), 32'hFC);
    checkOutput("wrap_pc_next",  32'(pc_next),  32'h00);

    // Reset asserted mid-DRAIN, then fetching restarts at the reset vector.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("pre_rst_drain_req", 32'(imem_req), 32'h1);
    #1;
    rst = 1'b1;
    imem_ack = 1'b0; instr_ready = 1'b0; br_valid = 1'b0; exc_valid = 1'b0;
    expQ.delete();
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    #1;
    rst = 1'b0;
    expQ.push_back(8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("restart_instr_pc", 32'(instr_pc), 32'h0);

    // Randomised run: variable memory latency, stalls and redirects.
    waitLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      logic       rdy;
      logic       br;
      logic       exc;
      logic [7:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 19) == 0);
      exc = ($urandom_range(0, 49) == 0);
      tgt = {6'($urandom_range(0, 63)), 2'b00};
      applyStimulus(1'b1, 1'b0, rdy, br, tgt, exc);
    end
    checkOutput("random_progress", 32'(acceptCount >= 200), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
